// File: rtl/touch_frame_latch_if.sv
// Touch conditioning bus: raw touchpad samples and frame marker in, latched screen coordinates out.
// No backpressure: inputs are sampled on internal ticks; out_valid qualifies out_x/out_y and holds until the next frame.
interface touch_frame_latch_if;
  logic [11:0] touch_x;
  logic [11:0] touch_y;
  logic [11:0] touch_z;
  logic        new_frame;
  logic [11:0] out_x;
  logic [11:0] out_y;
  logic        out_valid;
  logic        touch_down;
  logic        touch_up;
  logic [1:0]  state_dbg;

  modport master (
    output touch_x, touch_y, touch_z, new_frame,
    input  out_x, out_y, out_valid, touch_down, touch_up, state_dbg
  );

  modport slave (
    input  touch_x, touch_y, touch_z, new_frame,
    output out_x, out_y, out_valid, touch_down, touch_up, state_dbg
  );
endinterface

// File: rtl/touch_frame_latch.sv
// Touch conditioning between touchpad_controller and tft_driver: debounced press detection,
// sample averaging, saturating pixel calibration, and a once-per-frame output latch.
module touch_frame_latch #(
  parameter int SAMPLE_DIV = 1000,
  parameter int Z_THRESH   = 256,
  parameter int DEBOUNCE   = 3,
  parameter int AVG_LOG2   = 2,
  parameter int X_OFFSET   = 150,
  parameter int X_SHIFT    = 3,
  parameter int Y_OFFSET   = 300,
  parameter int Y_SHIFT    = 4,
  parameter int X_MAX      = 479,
  parameter int Y_MAX      = 271,
  parameter int NO_TOUCH   = 1000
) (
  input  logic                 cclk,
  input  logic                 rstb,
  touch_frame_latch_if.slave   bus
);

  localparam int DIV_W = (SAMPLE_DIV < 2) ? 1 : $clog2(SAMPLE_DIV);
  localparam int DEB_W = (DEBOUNCE < 2) ? 1 : $clog2(DEBOUNCE + 1);
  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int SMP_W = AVG_LOG2 + 1;

  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE - 1);
  localparam logic [SMP_W-1:0] SMP_LAST  = SMP_W'((1 << AVG_LOG2) - 1);
  localparam logic [11:0]      Z_TH12    = 12'(Z_THRESH);
  localparam logic [11:0]      X_OFF12   = 12'(X_OFFSET);
  localparam logic [11:0]      Y_OFF12   = 12'(Y_OFFSET);
  localparam logic [11:0]      X_MAX12   = 12'(X_MAX);
  localparam logic [11:0]      Y_MAX12   = 12'(Y_MAX);
  localparam logic [11:0]      NT12      = 12'(NO_TOUCH);

  typedef enum logic [1:0] {IDLE, PRESS_PEND, TOUCHED, RELEASE_PEND} state_t;

  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic             pressed;
  state_t           state;
  logic [DEB_W-1:0] cnt;
  logic [ACC_W-1:0] acc_x, acc_y, sum_x, sum_y;
  logic [SMP_W-1:0] samp_cnt;
  logic             do_acc;
  logic [11:0]      avg_x, avg_y;
  logic             avg_stb;
  logic [11:0]      pending_x, pending_y;
  logic             pending_valid;
  logic             touch_down_r, touch_up_r;
  logic             sync1, sync2, sync2_d, nf_edge;
  logic [11:0]      out_x_r, out_y_r;
  logic             out_valid_r;

  // Saturating calibration: below offset -> 0, otherwise shifted and clamped to the ceiling.
  function automatic logic [11:0] calib(input logic [11:0] avg, input logic [11:0] off,
                                        input int sh, input logic [11:0] maxv);
    logic [11:0] d;
    d = (avg < off) ? 12'd0 : 12'((avg - off) >> sh);
    return (d > maxv) ? maxv : d;
  endfunction

  assign tick    = (div_cnt == '0);
  assign pressed = (bus.touch_z >= Z_TH12);
  assign sum_x   = acc_x + ACC_W'(bus.touch_x);
  assign sum_y   = acc_y + ACC_W'(bus.touch_y);
  assign do_acc  = tick && pressed && (state == TOUCHED || state == RELEASE_PEND);
  assign nf_edge = sync2 & ~sync2_d;

  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      div_cnt <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // A pressed tick in RELEASE_PEND returns to TOUCHED and its sample is accumulated.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      state         <= IDLE;
      cnt           <= '0;
      acc_x         <= '0;
      acc_y         <= '0;
      samp_cnt      <= '0;
      avg_x         <= '0;
      avg_y         <= '0;
      avg_stb       <= 1'b0;
      pending_x     <= '0;
      pending_y     <= '0;
      pending_valid <= 1'b0;
      touch_down_r  <= 1'b0;
      touch_up_r    <= 1'b0;
    end else begin
      touch_down_r <= 1'b0;
      touch_up_r   <= 1'b0;
      avg_stb      <= 1'b0;

      if (avg_stb) begin
        pending_x     <= calib(avg_x, X_OFF12, X_SHIFT, X_MAX12);
        pending_y     <= calib(avg_y, Y_OFF12, Y_SHIFT, Y_MAX12);
        pending_valid <= 1'b1;
      end

      if (do_acc) begin
        if (samp_cnt == SMP_LAST) begin
          avg_x    <= 12'(sum_x >> AVG_LOG2);
          avg_y    <= 12'(sum_y >> AVG_LOG2);
          avg_stb  <= 1'b1;
          acc_x    <= '0;
          acc_y    <= '0;
          samp_cnt <= '0;
        end else begin
          acc_x    <= sum_x;
          acc_y    <= sum_y;
          samp_cnt <= samp_cnt + 1'b1;
        end
      end

      if (tick) begin
        case (state)
          IDLE: begin
            if (pressed) begin
              if (DEBOUNCE == 1) begin
                state        <= TOUCHED;
                touch_down_r <= 1'b1;
              end else begin
                state <= PRESS_PEND;
                cnt   <= DEB_W'(1);
              end
            end
          end
          PRESS_PEND: begin
            if (pressed) begin
              if (cnt == DEB_LAST) begin
                state        <= TOUCHED;
                touch_down_r <= 1'b1;
                cnt          <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state         <= IDLE;
              cnt           <= '0;
              pending_valid <= 1'b0;
            end
          end
          TOUCHED: begin
            if (!pressed) begin
              acc_x    <= '0;
              acc_y    <= '0;
              samp_cnt <= '0;
              if (DEBOUNCE == 1) begin
                state         <= IDLE;
                touch_up_r    <= 1'b1;
                pending_valid <= 1'b0;
              end else begin
                state <= RELEASE_PEND;
                cnt   <= DEB_W'(1);
              end
            end
          end
          RELEASE_PEND: begin
            if (!pressed) begin
              if (cnt == DEB_LAST) begin
                state         <= IDLE;
                touch_up_r    <= 1'b1;
                pending_valid <= 1'b0;
                cnt           <= '0;
              end else begin
                cnt <= cnt + 1'b1;
              end
            end else begin
              state <= TOUCHED;
              cnt   <= '0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  // Outputs load from pending as it stood before this edge, so a coinciding update waits a frame.
  always_ff @(posedge cclk or negedge rstb) begin
    if (!rstb) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      sync2_d     <= 1'b0;
      out_x_r     <= NT12;
      out_y_r     <= NT12;
      out_valid_r <= 1'b0;
    end else begin
      sync1   <= bus.new_frame;
      sync2   <= sync1;
      sync2_d <= sync2;
      if (nf_edge) begin
        out_x_r     <= pending_valid ? pending_x : NT12;
        out_y_r     <= pending_valid ? pending_y : NT12;
        out_valid_r <= pending_valid;
      end
    end
  end

  assign bus.out_x      = out_x_r;
  assign bus.out_y      = out_y_r;
  assign bus.out_valid  = out_valid_r;
  assign bus.touch_down = touch_down_r;
  assign bus.touch_up   = touch_up_r;
  assign bus.state_dbg  = state;

endmodule

// File: tb/tb_touch_frame_latch.sv
// Bench for touch_frame_latch: directed table and sequences plus random stimulus,
// every cycle compared against a tick-level behavioural model.
module tb_touch_frame_latch;
  localparam int SD  = 4;
  localparam int NT  = 1000;
  localparam int DEB = 3;

  logic cclk = 1'b0;
  logic rstb = 1'b0;

  touch_frame_latch_if bus();

  touch_frame_latch #(.SAMPLE_DIV(SD)) dut (
    .cclk (cclk),
    .rstb (rstb),
    .bus  (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 cclk = ~cclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int n_vec  = 0;
  int n_fail = 0;
  logic [24:0] exp_q[$];
  int n_down = 0;
  int n_up   = 0;

  typedef struct {
    int x; int y; int z;
    int ex; int ey; int ev;
  } vec_t;
  vec_t tbl[8];

  // ---------------- behavioural model ----------------
  int  m_cyc = 0;
  bit  p1 = 0, p2 = 0, p3 = 0;
  bit  m_touched = 0;
  int  m_run = 0;
  int  qx[$];
  int  qy[$];
  bit  m_pv = 0;
  int  m_px = 0, m_py = 0;
  bit  m_due = 0;
  int  m_dx = 0, m_dy = 0;
  int  e_x = NT, e_y = NT;
  bit  e_v = 0, e_dn = 0, e_up = 0;

  function automatic int calib(input int avg, input int off, input int div, input int mx);
    int c;
    c = (avg < off) ? 0 : (avg - off) / div;
    if (c > mx) c = mx;
    return c;
  endfunction

  task automatic model_reset();
    m_cyc = 0; p1 = 0; p2 = 0; p3 = 0;
    m_touched = 0; m_run = 0;
    qx.delete(); qy.delete();
    m_pv = 0; m_px = 0; m_py = 0; m_due = 0;
    e_x = NT; e_y = NT; e_v = 0; e_dn = 0; e_up = 0;
  endtask

  task automatic model_step(input bit nf, input int x, input int y, input int z);
    bit tick;
    bit pr;
    int sx, sy;
    tick = (m_cyc % SD) == 0;
    m_cyc++;
    e_dn = 0;
    e_up = 0;
    if (p2 && !p3) begin
      e_v = m_pv;
      e_x = m_pv ? m_px : NT;
      e_y = m_pv ? m_py : NT;
    end
    p3 = p2; p2 = p1; p1 = nf;
    if (m_due) begin
      m_pv = 1; m_px = m_dx; m_py = m_dy; m_due = 0;
    end
    if (tick) begin
      pr = (z >= 256);
      if (pr != m_touched) begin
        m_run++;
        qx.delete(); qy.delete();
        if (m_run == DEB) begin
          m_touched = pr;
          m_run = 0;
          if (pr) e_dn = 1;
          else begin
            e_up = 1;
            m_pv = 0;
          end
        end
      end else begin
        m_run = 0;
        if (m_touched) begin
          qx.push_back(x);
          qy.push_back(y);
          if (qx.size() == 4) begin
            sx = 0; sy = 0;
            foreach (qx[i]) sx += qx[i];
            foreach (qy[i]) sy += qy[i];
            m_dx = calib(sx / 4, 150, 8, 479);
            m_dy = calib(sy / 4, 300, 16, 271);
            m_due = 1;
            qx.delete(); qy.delete();
          end
        end
      end
    end
  endtask

  // Per-cycle compare of every output against the model.
  always @(posedge cclk) begin
    if (!rstb) model_reset();
    else model_step(bus.new_frame, int'(bus.touch_x), int'(bus.touch_y), int'(bus.touch_z));
    #1;
    if (bus.touch_down === 1'b1) n_down++;
    if (bus.touch_up === 1'b1) n_up++;
    n_vec++;
    if (bus.out_x !== e_x[11:0] || bus.out_y !== e_y[11:0] || bus.out_valid !== e_v ||
        bus.touch_down !== e_dn || bus.touch_up !== e_up) begin
      n_fail++;
      $display("FAIL model_cycle t=%0t: got x=%0d y=%0d v=%0b dn=%0b up=%0b, want x=%0d y=%0d v=%0b dn=%0b up=%0b",
               $time, bus.out_x, bus.out_y, bus.out_valid, bus.touch_down, bus.touch_up,
               e_x, e_y, e_v, e_dn, e_up);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic check_out(input string name, input int ex, input int ey, input int ev);
    check({name, "_x"}, 32'(bus.out_x), ex);
    check({name, "_y"}, 32'(bus.out_y), ey);
    check({name, "_valid"}, 32'(bus.out_valid), ev);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge cclk);
  endtask

  task automatic windows(input int n);
    cycles(n * SD);
  endtask

  task automatic set_in(input int x, input int y, input int z);
    bus.touch_x = 12'(x);
    bus.touch_y = 12'(y);
    bus.touch_z = 12'(z);
  endtask

  task automatic do_reset();
    @(negedge cclk);
    rstb = 1'b0;
    cycles(2);
    rstb = 1'b1;
  endtask

  task automatic frame();
    bus.new_frame = 1'b1;
    cycles(3);
    bus.new_frame = 1'b0;
    cycles(2);
  endtask

  task automatic wait_cyc(input int k);
    int guard;
    guard = 0;
    while (m_cyc < k && guard < 1000) begin
      @(negedge cclk);
      guard++;
    end
    check("wait_cyc", m_cyc, k);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d0, u0;
    bit zp;
    logic [24:0] e, got;

    tbl[0] = '{1000, 2000, 3000, 106, 106, 1};
    tbl[1] = '{100,  4095, 3000, 0,   237, 1};
    tbl[2] = '{4095, 300,  3000, 479, 0,   1};
    tbl[3] = '{3982, 4095, 3000, 479, 237, 1};
    tbl[4] = '{3990, 1000, 3000, 479, 43,  1};
    tbl[5] = '{157,  315,  256,  0,   0,   1};
    tbl[6] = '{158,  316,  4095, 1,   1,   1};
    tbl[7] = '{1000, 2000, 255,  NT,  NT,  0};

    set_in(0, 0, 0);
    bus.new_frame = 1'b0;
    cycles(3);
    check_out("reset_initial", NT, NT, 0);
    rstb = 1'b1;

    // press and average
    do_reset();
    d0 = n_down;
    set_in(1000, 2000, 3000);
    windows(3);
    check("press_down_pulses", n_down - d0, 1);
    set_in(996, 2000, 3000);  windows(1);
    set_in(1000, 2000, 3000); windows(1);
    set_in(1004, 2000, 3000); windows(1);
    set_in(1000, 2000, 3000); windows(1);
    windows(1);
    check_out("avg_before_frame", NT, NT, 0);
    frame();
    check_out("avg_frame", 106, 106, 1);

    // async reset with no clock edge, then held across edges
    @(negedge cclk);
    rstb = 1'b0;
    #1;
    check_out("reset_noclk", NT, NT, 0);
    d0 = n_down;
    u0 = n_up;
    cycles(3);
    check_out("reset_held", NT, NT, 0);
    check("reset_no_pulses", (n_down - d0) + (n_up - u0), 0);
    rstb = 1'b1;

    // table: clamp / threshold boundaries
    do_reset();
    for (int i = 0; i < 8; i++) begin
      set_in(tbl[i].x, tbl[i].y, 0);
      windows(4);
      set_in(tbl[i].x, tbl[i].y, tbl[i].z);
      windows(9);
      frame();
      exp_q.push_back({tbl[i].ev[0], tbl[i].ex[11:0], tbl[i].ey[11:0]});
      got = {bus.out_valid, bus.out_x, bus.out_y};
      e = exp_q.pop_front();
      check($sformatf("table_%0d", i), 32'(got), 32'(e));
    end

    // bounce
    do_reset();
    d0 = n_down;
    for (int i = 0; i < 8; i++) begin
      set_in(1000, 2000, (i % 2 == 0) ? 3000 : 0);
      windows(1);
    end
    check("bounce_down_pulses", n_down - d0, 0);
    frame();
    check_out("bounce_frame", NT, NT, 0);

    // release
    do_reset();
    set_in(1000, 2000, 3000);
    windows(9);
    frame();
    check_out("release_pre", 106, 106, 1);
    u0 = n_up;
    set_in(1000, 2000, 0);
    windows(3);
    check("release_up_pulses", n_up - u0, 1);
    frame();
    check_out("release_frame", NT, NT, 0);
    set_in(1000, 2000, 3000);
    windows(9);
    u0 = n_up;
    set_in(1000, 2000, 0);
    windows(2);
    set_in(1000, 2000, 3000);
    windows(6);
    check("short_release_up_pulses", n_up - u0, 0);
    frame();
    check_out("short_release_frame", 106, 106, 1);

    // pending update colliding with the frame latch edge
    do_reset();
    set_in(1000, 2000, 3000);
    wait_cyc(26);
    set_in(1800, 2000, 3000);
    wait_cyc(39);
    bus.new_frame = 1'b1;
    @(posedge cclk);
    @(posedge cclk);
    #1;
    check_out("collide_edge2", NT, NT, 0);
    @(posedge cclk);
    #1;
    check_out("collide_edge3", 106, 106, 1);
    @(negedge cclk);
    bus.new_frame = 1'b0;
    cycles(2);
    windows(6);
    frame();
    check_out("collide_next", 206, 106, 1);

    // random stimulus against the model
    do_reset();
    zp = 0;
    for (int w = 0; w < 250; w++) begin
      if ($urandom_range(0, 3) == 0) zp = !zp;
      bus.touch_z = zp ? 12'($urandom_range(256, 4095)) : 12'($urandom_range(0, 255));
      for (int c = 0; c < SD; c++) begin
        if ($urandom_range(0, 1) == 0) begin
          bus.touch_x = 12'($urandom_range(0, 4095));
          bus.touch_y = 12'($urandom_range(0, 4095));
        end
        if ($urandom_range(0, 5) == 0) bus.new_frame = ~bus.new_frame;
        @(negedge cclk);
      end
    end
    bus.new_frame = 1'b0;
    cycles(4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
